// File: rtl/free_list_if.sv
// Free-list port bundle between the rename/commit logic and the free list.
//   master : rename/commit side (drives take/put/rewind requests)
//   slave  : free list (returns granted tags, checkpoints, occupancy, error)
// Lane k of every packed lane vector sits at [k*W +: W]; lane 0 is the oldest.
interface free_list_if #(
    parameter int LANES = 4,
    parameter int TAG_W = 6,
    parameter int PTR_W = 7
);
    logic [LANES-1:0]       take;
    logic                   enable_take;
    logic [LANES*TAG_W-1:0] take_tag;
    logic [LANES*PTR_W-1:0] take_ptr;
    logic                   take_stall;
    logic [LANES-1:0]       put;
    logic                   enable_put;
    logic [LANES*TAG_W-1:0] put_tag;
    logic                   rewind;
    logic [PTR_W-1:0]       rewind_ptr;
    logic [PTR_W-1:0]       free_count;
    logic                   overflow_err;

    modport master (
        output take, enable_take, put, enable_put, put_tag, rewind, rewind_ptr,
        input  take_tag, take_ptr, take_stall, free_count, overflow_err
    );

    modport slave (
        input  take, enable_take, put, enable_put, put_tag, rewind, rewind_ptr,
        output take_tag, take_ptr, take_stall, free_count, overflow_err
    );
endinterface

// File: rtl/free_list_gen.sv
// Parametrised physical-register free list for the rename stage.
// Circular queue of free tags: rename pops up to LANES tags per cycle from the
// front, commit pushes up to LANES freed tags per cycle at the back.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   fl       : free_list_if slave (take/put/rewind requests in; granted tags,
//              per-lane front checkpoints, stall, occupancy, sticky overflow out)
// Pointers carry one extra wrap bit so full (count = NUM_PHYS) and empty are
// distinguishable; the array index is the low TAG_W bits.
module free_list_gen #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int LANES    = 4,
    parameter int TAG_W    = $clog2(NUM_PHYS),
    parameter int PTR_W    = TAG_W + 1
) (
    input logic        clk,
    input logic        reset_n,
    free_list_if.slave fl
);

    // Wide enough for any occupancy plus up to 8 lanes without wrapping.
    localparam int SUM_W     = PTR_W + 4;
    localparam int NUM_FREE0 = NUM_PHYS - NUM_ARCH;

    logic [TAG_W-1:0] stack_q [NUM_PHYS];
    logic [TAG_W-1:0] stack_d [NUM_PHYS];
    logic [PTR_W-1:0] front_q, front_d;
    logic [PTR_W-1:0] back_q, back_d;
    logic             overflow_q, overflow_d;

    logic [PTR_W-1:0] free_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [SUM_W-1:0] take_cnt;
    logic [SUM_W-1:0] put_cnt;
    logic [SUM_W-1:0] wr_cnt;
    logic [SUM_W-1:0] popped;
    logic [SUM_W-1:0] occ_after;
    logic             take_stall;
    logic             take_pop;
    logic             put_ovf;
    logic             put_ok;

    assign free_count = back_q - front_q;

    // Compacted take lanes: each requesting lane gets the next unclaimed tag;
    // idle lanes simply show the tag their successor would get.
    always_comb begin
        take_cnt    = '0;
        rd_ptr      = '0;
        fl.take_tag = '0;
        fl.take_ptr = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_ptr = front_q + PTR_W'(take_cnt);
            fl.take_tag[k*TAG_W +: TAG_W] = stack_q[rd_ptr[TAG_W-1:0]];
            take_cnt = take_cnt + SUM_W'(fl.take[k]);
            fl.take_ptr[k*PTR_W +: PTR_W] = front_q + PTR_W'(take_cnt);
        end
    end

    always_comb begin
        put_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            put_cnt = put_cnt + SUM_W'(fl.put[k]);
        end
    end

    // Take is all-or-nothing, and a rewind wins over any take in the same cycle.
    assign take_stall = take_cnt > SUM_W'(free_count);
    assign take_pop   = fl.enable_take & ~take_stall & ~fl.rewind;
    assign popped     = take_pop ? take_cnt : '0;

    // Occupancy after this edge; popped never exceeds free_count so no underflow.
    assign occ_after  = SUM_W'(free_count) - popped + put_cnt;
    assign put_ovf    = occ_after > SUM_W'(NUM_PHYS);
    assign put_ok     = fl.enable_put & ~put_ovf;

    always_comb begin
        stack_d = stack_q;
        wr_cnt  = '0;
        wr_ptr  = '0;
        for (int k = 0; k < LANES; k++) begin
            wr_ptr = back_q + PTR_W'(wr_cnt);
            if (put_ok && fl.put[k]) begin
                stack_d[wr_ptr[TAG_W-1:0]] = fl.put_tag[k*TAG_W +: TAG_W];
            end
            wr_cnt = wr_cnt + SUM_W'(fl.put[k]);
        end
    end

    always_comb begin
        front_d = front_q;
        if (fl.rewind) begin
            front_d = fl.rewind_ptr;
        end else if (take_pop) begin
            front_d = front_q + PTR_W'(take_cnt);
        end
        back_d     = put_ok ? back_q + PTR_W'(put_cnt) : back_q;
        overflow_d = overflow_q | (fl.enable_put & put_ovf);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_q    <= '0;
            back_q     <= PTR_W'(NUM_FREE0);
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_PHYS; i++) begin
                stack_q[i] <= (i < NUM_FREE0) ? TAG_W'(NUM_ARCH + i) : '0;
            end
        end else begin
            front_q    <= front_d;
            back_q     <= back_d;
            overflow_q <= overflow_d;
            stack_q    <= stack_d;
        end
    end

    assign fl.take_stall   = take_stall;
    assign fl.free_count   = free_count;
    assign fl.overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list_gen.sv
// Bench for free_list_gen: directed scenarios plus a randomized run checked
// against a circular-queue reference model kept here.
module tb_free_list_gen;
    localparam int NP = 64;
    localparam int NA = 32;
    localparam int L  = 4;
    localparam int TW = 6;
    localparam int PW = 7;
    localparam int PMOD = 2 * NP;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    free_list_if #(.LANES(L), .TAG_W(TW), .PTR_W(PW)) fl ();

    free_list_gen #(
        .NUM_PHYS(NP), .NUM_ARCH(NA), .LANES(L), .TAG_W(TW), .PTR_W(PW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .fl     (fl)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: free tags held in an array addressed by wrap-around pointers.
    int m_stack [NP];
    int m_front;
    int m_back;
    bit m_ovf;

    function automatic int popc(logic [L-1:0] v, int upto);
        int n = 0;
        for (int i = 0; i < upto; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int m_count();
        return (m_back - m_front + PMOD) % PMOD;
    endfunction

    function automatic int exp_tag(int k);
        return m_stack[(m_front + popc(fl.take, k)) % NP];
    endfunction

    function automatic int exp_ptr(int k);
        return (m_front + popc(fl.take, k) + int'(fl.take[k])) % PMOD;
    endfunction

    function automatic bit exp_stall();
        return popc(fl.take, L) > m_count();
    endfunction

    task automatic model_reset();
        m_front = 0;
        m_back  = NP - NA;
        m_ovf   = 1'b0;
        for (int i = 0; i < NP; i++) m_stack[i] = (i < NP - NA) ? NA + i : 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int pop;
        int pcnt;
        int pre;
        pop  = (fl.enable_take && !exp_stall() && !fl.rewind) ? popc(fl.take, L) : 0;
        pcnt = popc(fl.put, L);
        if (fl.enable_put) begin
            if (m_count() - pop + pcnt > NP) begin
                m_ovf = 1'b1;
            end else begin
                pre = 0;
                for (int k = 0; k < L; k++) begin
                    if (fl.put[k]) begin
                        m_stack[(m_back + pre) % NP] = int'(fl.put_tag[k*TW +: TW]);
                        pre++;
                    end
                end
                m_back = (m_back + pcnt) % PMOD;
            end
        end
        if (fl.rewind) m_front = int'(fl.rewind_ptr);
        else m_front = (m_front + pop) % PMOD;
    endtask

    task automatic idle_inputs();
        fl.take = '0;        fl.enable_take = 1'b0;
        fl.put = '0;         fl.enable_put = 1'b0;
        fl.put_tag = '0;     fl.rewind = 1'b0;
        fl.rewind_ptr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic clock_edges(int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        fl.take = 4'b1111;
        #1;
        checks++;
        if (fl.free_count !== 7'd32) begin
            errors++; $display("FAIL reset_count: got %0d expected 32", fl.free_count);
        end
        for (int k = 0; k < L; k++) begin
            checks++;
            if (fl.take_tag[k*TW +: TW] !== TW'(NA + k)) begin
                errors++;
                $display("FAIL reset_tag lane%0d: got %0d expected %0d", k, fl.take_tag[k*TW +: TW], NA + k);
            end
        end
        checks++;
        if (fl.take_stall !== 1'b0 || fl.overflow_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got stall=%b ovf=%b expected 0 0", fl.take_stall, fl.overflow_err);
        end
    endtask

    task automatic test_take_lanes();
        int exp_t [L];
        int exp_p [L];
        exp_t = '{32, 33, 33, 34};
        exp_p = '{1, 1, 2, 3};
        do_reset();
        fl.take = 4'b1101;
        fl.enable_take = 1'b1;
        #1;
        for (int k = 0; k < L; k++) begin
            if (k != 1) begin
                checks++;
                if (fl.take_tag[k*TW +: TW] !== TW'(exp_t[k])) begin
                    errors++;
                    $display("FAIL take_tag lane%0d: got %0d expected %0d", k, fl.take_tag[k*TW +: TW], exp_t[k]);
                end
            end
            checks++;
            if (fl.take_ptr[k*PW +: PW] !== PW'(exp_p[k])) begin
                errors++;
                $display("FAIL take_ptr lane%0d: got %0d expected %0d", k, fl.take_ptr[k*PW +: PW], exp_p[k]);
            end
        end
        clock_edges(1);
        fl.enable_take = 1'b0;
        fl.take = 4'b0001;
        #1;
        checks++;
        if (fl.free_count !== 7'd29 || fl.take_tag[0 +: TW] !== 6'd35) begin
            errors++;
            $display("FAIL take_after: got count=%0d tag0=%0d expected 29 35", fl.free_count, fl.take_tag[0 +: TW]);
        end
    endtask

    task automatic test_drain_stall();
        do_reset();
        fl.take = 4'b1111;
        fl.enable_take = 1'b1;
        clock_edges(8);
        #1;
        checks++;
        if (fl.free_count !== 7'd0 || fl.take_stall !== 1'b1) begin
            errors++;
            $display("FAIL drain: got count=%0d stall=%b expected 0 1", fl.free_count, fl.take_stall);
        end
        clock_edges(1);
        fl.enable_take = 1'b0;
        fl.take = 4'b0000;
        #1;
        checks++;
        if (fl.free_count !== 7'd0 || fl.take_ptr[0 +: PW] !== 7'd32) begin
            errors++;
            $display("FAIL stall_hold: got count=%0d front=%0d expected 0 32", fl.free_count, fl.take_ptr[0 +: PW]);
        end
        fl.take = 4'b0001;
        #1;
        checks++;
        if (fl.take_stall !== 1'b1) begin
            errors++; $display("FAIL stall_single: got %b expected 1", fl.take_stall);
        end
    endtask

    task automatic test_put_take();
        int exp_t [L];
        exp_t = '{62, 63, 5, 9};
        do_reset();
        fl.put = 4'b0110;
        fl.put_tag = {6'd0, 6'd9, 6'd5, 6'd0};
        fl.enable_put = 1'b1;
        fl.take = 4'b0011;
        fl.enable_take = 1'b1;
        clock_edges(1);
        idle_inputs();
        fl.take = 4'b0001;
        #1;
        checks++;
        if (fl.free_count !== 7'd32 || fl.take_ptr[0 +: PW] !== 7'd3) begin
            errors++;
            $display("FAIL put_take: got count=%0d ptr0=%0d expected 32 3", fl.free_count, fl.take_ptr[0 +: PW]);
        end
        fl.take = 4'b1111;
        fl.enable_take = 1'b1;
        clock_edges(7);
        fl.enable_take = 1'b0;
        #1;
        for (int k = 0; k < L; k++) begin
            checks++;
            if (fl.take_tag[k*TW +: TW] !== TW'(exp_t[k])) begin
                errors++;
                $display("FAIL put_visible lane%0d: got %0d expected %0d", k, fl.take_tag[k*TW +: TW], exp_t[k]);
            end
        end
    endtask

    task automatic test_rewind();
        do_reset();
        fl.take = 4'b1111;
        fl.enable_take = 1'b1;
        clock_edges(3);
        fl.rewind = 1'b1;
        fl.rewind_ptr = 7'd0;
        clock_edges(1);
        fl.rewind = 1'b0;
        fl.enable_take = 1'b0;
        #1;
        checks++;
        if (fl.free_count !== 7'd32 || fl.take_tag[0 +: TW] !== 6'd32 || fl.take_ptr[0 +: PW] !== 7'd1) begin
            errors++;
            $display("FAIL rewind: got count=%0d tag0=%0d ptr0=%0d expected 32 32 1",
                     fl.free_count, fl.take_tag[0 +: TW], fl.take_ptr[0 +: PW]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fl.put = 4'b1111;
        fl.enable_put = 1'b1;
        for (int c = 0; c < 8; c++) begin
            fl.put_tag = 24'($urandom);
            clock_edges(1);
        end
        #1;
        checks++;
        if (fl.free_count !== 7'd64 || fl.overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL fill: got count=%0d ovf=%b expected 64 0", fl.free_count, fl.overflow_err);
        end
        clock_edges(1);
        idle_inputs();
        fl.take = 4'b0001;
        #1;
        checks++;
        if (fl.free_count !== 7'd64 || fl.overflow_err !== 1'b1 || fl.take_tag[0 +: TW] !== 6'd32) begin
            errors++;
            $display("FAIL overflow: got count=%0d ovf=%b tag0=%0d expected 64 1 32",
                     fl.free_count, fl.overflow_err, fl.take_tag[0 +: TW]);
        end
        clock_edges(2);
        #1;
        checks++;
        if (fl.overflow_err !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: got %b expected 1", fl.overflow_err);
        end
    endtask

    // Reset dropped mid-cycle must take effect without waiting for a clock edge.
    task automatic test_async_reset();
        fl.take = 4'b1111;
        fl.enable_take = 1'b1;
        clock_edges(2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (fl.free_count !== 7'd32 || fl.overflow_err !== 1'b0 || fl.take_tag[0 +: TW] !== 6'd32) begin
            errors++;
            $display("FAIL async_reset: got count=%0d ovf=%b tag0=%0d expected 32 0 32",
                     fl.free_count, fl.overflow_err, fl.take_tag[0 +: TW]);
        end
        @(negedge clk);
        idle_inputs();
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int off;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            fl.take        = L'($urandom);
            fl.enable_take = ($urandom_range(0, 99) < 70);
            fl.put         = L'($urandom);
            fl.enable_put  = ($urandom_range(0, 99) < 45);
            fl.put_tag     = 24'($urandom);
            fl.rewind      = ($urandom_range(0, 99) < 8);
            off            = $urandom_range(0, NP - m_count());
            fl.rewind_ptr  = PW'((m_front - off + PMOD) % PMOD);
            #1;
            for (int k = 0; k < L; k++) begin
                checks++;
                if (fl.take_tag[k*TW +: TW] !== TW'(exp_tag(k))) begin
                    errors++;
                    $display("FAIL rand_tag c%0d lane%0d: got %0d expected %0d", c, k, fl.take_tag[k*TW +: TW], exp_tag(k));
                end
                checks++;
                if (fl.take_ptr[k*PW +: PW] !== PW'(exp_ptr(k))) begin
                    errors++;
                    $display("FAIL rand_ptr c%0d lane%0d: got %0d expected %0d", c, k, fl.take_ptr[k*PW +: PW], exp_ptr(k));
                end
            end
            checks++;
            if (fl.free_count !== PW'(m_count()) || fl.take_stall !== exp_stall() || fl.overflow_err !== m_ovf) begin
                errors++;
                $display("FAIL rand_state c%0d: got count=%0d stall=%b ovf=%b expected %0d %b %b",
                         c, fl.free_count, fl.take_stall, fl.overflow_err, m_count(), exp_stall(), m_ovf);
            end
            clock_edges(1);
            // Periodically clear the sticky error so later puts are exercised again.
            if (c % 150 == 149) do_reset();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_take_lanes();
        test_drain_stall();
        test_put_take();
        test_rewind();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
